unidade_controle_niveis: RTL

Parametrised level/lives controller for the LED-matrix memory puzzle. Owns the level counter, lives counter and an optional per-level timeout internally, and sequences the datapath through preparation, level play, retry-on-error, win and loss. Drives the same `contaN`/`zeraN`/`zeraM` strobes the datapath already consumes, adds loss and timeout handling, and exposes level/lives for display.

---
 rtl/unidade_controle_niveis.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/unidade_controle_niveis.sv
// Level/lives controller for the LED-matrix memory puzzle: sequences level play, retries, win and loss.
// Optional per-level timeout enabled by defining UNIDADE_CONTROLE_TIMEOUT_EN.
module unidade_controle_niveis #(
   parameter int N_NIVEIS       = 8,
   parameter int NIVEL_W        = 3,
   parameter int VIDAS          = 3,
   parameter int VIDAS_W        = 2,
   parameter int TIMEOUT_CICLOS = 50_000_000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic               nivel_concluido,
   input  logic               nivel_errado,
   output logic               ganhou,
   output logic               perdeu,
   output logic               estourou,
   output logic               contaN,
   output logic               zeraN,
   output logic               zeraM,
   output logic [NIVEL_W-1:0] nivel,
   output logic [VIDAS_W-1:0] vidas,
   output logic [4:0]         db_estado
);

   typedef enum logic [3:0] {
      INICIAL       = 4'd0,
      PREPARACAO    = 4'd1,
      INIC_NIVEL    = 4'd2,
      JOGANDO       = 4'd3,
      CHECA_ULTIMO  = 4'd4,
      PROXIMO_NIVEL = 4'd5,
      GANHOU        = 4'd6,
      ERRO_NIVEL    = 4'd7,
      CHECA_VIDAS   = 4'd8,
      PERDEU        = 4'd9
   } estado_t;

   localparam logic [NIVEL_W-1:0] NIVEL_MAX = NIVEL_W'(N_NIVEIS - 1);
   localparam logic [VIDAS_W-1:0] VIDAS_INI = VIDAS_W'(VIDAS);

   estado_t            estado_q, estado_d;
   logic [NIVEL_W-1:0] nivel_q, nivel_d;
   logic [VIDAS_W-1:0] vidas_q, vidas_d;
   logic               timeout_s;
   logic               estourou_q;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
   localparam int              TO_W   = $clog2(TIMEOUT_CICLOS);
   localparam logic [TO_W-1:0] TO_FIM = TO_W'(TIMEOUT_CICLOS - 1);

   logic [TO_W-1:0] tempo_q, tempo_d;
   logic            estourou_d;

   assign timeout_s = (estado_q == JOGANDO) && (tempo_q == TO_FIM);

   always_comb begin
      tempo_d    = {TO_W{1'b0}};
      estourou_d = estourou_q;
      if (estado_q == JOGANDO) begin
         tempo_d = tempo_q + TO_W'(1);
      end else begin
         tempo_d = {TO_W{1'b0}};
      end
      // The flag records why ERRO_NIVEL was entered; a wrong move outranks the timeout.
      if ((estado_q == JOGANDO) && !nivel_concluido && !nivel_errado && timeout_s) begin
         estourou_d = 1'b1;
      end else if ((estado_q == INIC_NIVEL) || (estado_q == PREPARACAO)) begin
         estourou_d = 1'b0;
      end else begin
         estourou_d = estourou_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tempo_q    <= {TO_W{1'b0}};
         estourou_q <= 1'b0;
      end else begin
         tempo_q    <= tempo_d;
         estourou_q <= estourou_d;
      end
   end
`else
   assign timeout_s  = 1'b0 && (TIMEOUT_CICLOS > 0);
   assign estourou_q = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= INICIAL;
         nivel_q  <= {NIVEL_W{1'b0}};
         vidas_q  <= VIDAS_INI;
      end else begin
         estado_q <= estado_d;
         nivel_q  <= nivel_d;
         vidas_q  <= vidas_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL, GANHOU, PERDEU: begin
            if (iniciar) estado_d = PREPARACAO;
            else         estado_d = estado_q;
         end
         PREPARACAO:    estado_d = INIC_NIVEL;
         INIC_NIVEL:    estado_d = JOGANDO;
         JOGANDO: begin
            if (nivel_concluido)                estado_d = CHECA_ULTIMO;
            else if (nivel_errado || timeout_s) estado_d = ERRO_NIVEL;
            else                                estado_d = JOGANDO;
         end
         CHECA_ULTIMO: begin
            if (nivel_q == NIVEL_MAX) estado_d = GANHOU;
            else                      estado_d = PROXIMO_NIVEL;
         end
         PROXIMO_NIVEL: estado_d = INIC_NIVEL;
         ERRO_NIVEL:    estado_d = CHECA_VIDAS;
         CHECA_VIDAS: begin
            if (vidas_q == {VIDAS_W{1'b0}}) estado_d = PERDEU;
            else                            estado_d = INIC_NIVEL;
         end
         default:       estado_d = INICIAL;
      endcase
   end

   always_comb begin
      nivel_d = nivel_q;
      vidas_d = vidas_q;
      case (estado_q)
         INICIAL, PREPARACAO: begin
            nivel_d = {NIVEL_W{1'b0}};
            vidas_d = VIDAS_INI;
         end
         PROXIMO_NIVEL: begin
            if (nivel_q != NIVEL_MAX) nivel_d = nivel_q + NIVEL_W'(1);
            else                      nivel_d = nivel_q;
         end
         ERRO_NIVEL: begin
            if (vidas_q != {VIDAS_W{1'b0}}) vidas_d = vidas_q - VIDAS_W'(1);
            else                            vidas_d = vidas_q;
         end
         default: begin
            nivel_d = nivel_q;
            vidas_d = vidas_q;
         end
      endcase
   end

   always_comb begin
      ganhou    = 1'b0;
      perdeu    = 1'b0;
      estourou  = 1'b0;
      contaN    = 1'b0;
      zeraN     = 1'b0;
      zeraM     = 1'b0;
      db_estado = 5'b11111;
      case (estado_q)
         INICIAL:       begin zeraN = 1'b1; zeraM = 1'b1; db_estado = 5'd0; end
         PREPARACAO:    begin zeraN = 1'b1; zeraM = 1'b1; db_estado = 5'd1; end
         INIC_NIVEL:    begin zeraM = 1'b1; db_estado = 5'd2; end
         JOGANDO:       db_estado = 5'd3;
         CHECA_ULTIMO:  db_estado = 5'd4;
         PROXIMO_NIVEL: begin contaN = 1'b1; db_estado = 5'd5; end
         GANHOU:        begin ganhou = 1'b1; db_estado = 5'd6; end
         ERRO_NIVEL:    begin zeraM = 1'b1; estourou = estourou_q; db_estado = 5'd7; end
         CHECA_VIDAS:   db_estado = 5'd8;
         PERDEU:        begin perdeu = 1'b1; db_estado = 5'd9; end
         default:       db_estado = 5'b11111;
      endcase
   end

   assign nivel = nivel_q;
   assign vidas = vidas_q;

endmodule
